// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
// Package     : button_event_pkg
// Description : Shared types and helpers for the button event generator.
//               Holds the per-channel FSM state encoding and a counter-width
//               helper used to size debounce/hold/repeat counters.
// Revision    : 1.0 - initial release
// ============================================================================
package button_event_pkg;

  // Per-channel event FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_e;

  // Width of a counter that must hold values 0 .. n-1 (never below 1 bit)
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/button_channel.sv
`default_nettype none
// ============================================================================
// Module      : button_channel
// Description : One button channel: optional polarity inversion, 2-FF
//               synchroniser, debounce counter and a press/long/repeat event
//               FSM with registered one-cycle pulse outputs.
// Ports       : clk, rst           - clock, synchronous active-high reset
//               btn_i              - raw asynchronous button input
//               en_i               - channel enable (0 suppresses all events)
//               rep_en_i           - auto-repeat enable
//               level_o            - debounced pressed level
//               press_o/release_o  - 1-cycle pulses on accepted edges
//               long_o/repeat_o    - 1-cycle long-press and repeat pulses
// Revision    : 1.0 - initial release
// ============================================================================
module button_channel
  import button_event_pkg::*;
#(
  parameter int DEB_CYCLES    = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  input  logic en_i,
  input  logic rep_en_i,
  output logic level_o,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o
);

  localparam int DEB_W  = cnt_width(DEB_CYCLES);
  localparam int HOLD_W = cnt_width(LONG_CYCLES);
  localparam int REP_W  = cnt_width(REPEAT_CYCLES);

  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic              w_btn;
  logic              sync1_q;
  logic              sync2_q;
  logic              stable_q;
  logic [DEB_W-1:0]  deb_cnt_q;
  logic              level_q;
  state_e            state_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              press_q;
  logic              release_q;
  logic              long_q;
  logic              repeat_q;
  logic              w_rise;
  logic              w_fall;

  assign w_btn = ACTIVE_LOW ? ~btn_i : btn_i;

  // Synchroniser and debounce. level_q is stable_q delayed by one cycle, so
  // it doubles as the previous-stable value used for edge detection and
  // lines up exactly with the press/release pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      stable_q  <= 1'b0;
      deb_cnt_q <= '0;
      level_q   <= 1'b0;
    end else begin
      sync1_q <= w_btn;
      sync2_q <= sync1_q;
      level_q <= stable_q;
      if (sync2_q != stable_q) begin
        if (deb_cnt_q == DEB_LAST) begin
          stable_q  <= sync2_q;
          deb_cnt_q <= '0;
        end else begin
          deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
      end else begin
        // Any return to the accepted level restarts the qualification.
        deb_cnt_q <= '0;
      end
    end
  end

  assign w_rise = stable_q & ~level_q;
  assign w_fall = ~stable_q & level_q;

  // Event FSM. A release is tested before any terminal count so it wins
  // when both happen on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
      if (!en_i) begin
        state_q    <= ST_IDLE;
        hold_cnt_q <= '0;
        rep_cnt_q  <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            // Only a fresh rise counts; enabling with the button already
            // down does not produce a press.
            if (w_rise) begin
              press_q    <= 1'b1;
              hold_cnt_q <= '0;
              state_q    <= ST_PRESS;
            end
          end
          ST_PRESS: begin
            if (w_fall) begin
              release_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else if (hold_cnt_q == HOLD_LAST) begin
              long_q    <= 1'b1;
              rep_cnt_q <= '0;
              state_q   <= ST_LONG;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
          ST_LONG: begin
            if (w_fall) begin
              release_q <= 1'b1;
              state_q   <= ST_IDLE;
            end else if (!rep_en_i) begin
              rep_cnt_q <= '0;
            end else if (rep_cnt_q == REP_LAST) begin
              repeat_q  <= 1'b1;
              rep_cnt_q <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign level_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;
  assign repeat_o  = repeat_q;

endmodule
`default_nettype wire

// File: rtl/button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : button_event_gen
// Description : N-channel button event generator. Each channel independently
//               synchronises, debounces and decodes its button into press,
//               release, long-press and auto-repeat pulses plus a clean level.
// Ports       : clk, rst   - clock, synchronous active-high reset
//               btn_i      - raw button inputs [N_CH]
//               en_i       - per-channel enables [N_CH]
//               rep_en_i   - global auto-repeat enable
//               level_o    - debounced pressed levels [N_CH]
//               press_o, release_o, long_o, repeat_o - event pulses [N_CH]
// Revision    : 1.0 - initial release
// ============================================================================
module button_event_gen
  import button_event_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DEB_CYCLES    = 16,
  parameter int LONG_CYCLES   = 1000,
  parameter int REPEAT_CYCLES = 200,
  parameter bit ACTIVE_LOW    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] en_i,
  input  logic            rep_en_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .DEB_CYCLES    (DEB_CYCLES),
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES),
      .ACTIVE_LOW    (ACTIVE_LOW)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_i     (btn_i[i]),
      .en_i      (en_i[i]),
      .rep_en_i  (rep_en_i),
      .level_o   (level_o[i]),
      .press_o   (press_o[i]),
      .release_o (release_o[i]),
      .long_o    (long_o[i]),
      .repeat_o  (repeat_o[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_event_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_event_gen
// Description : Directed self-checking bench for button_event_gen. Runs an
//               active-high instance and an active-low instance fed with the
//               inverted buttons; both must behave identically.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event_gen;

  localparam int N_CH = 2;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] btn_n;
  logic [N_CH-1:0] en = '1;
  logic            rep_en = 1'b1;

  logic [N_CH-1:0] level, press, rel, lng, rpt;
  logic [N_CH-1:0] al_level, al_press, al_rel, al_lng, al_rpt;

  assign btn_n = ~btn;

  always #5 clk = ~clk;

  button_event_gen #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_i(btn), .en_i(en), .rep_en_i(rep_en),
    .level_o(level), .press_o(press), .release_o(rel), .long_o(lng), .repeat_o(rpt)
  );

  button_event_gen #(
    .N_CH(N_CH), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_i(btn_n), .en_i(en), .rep_en_i(rep_en),
    .level_o(al_level), .press_o(al_press), .release_o(al_rel), .long_o(al_lng), .repeat_o(al_rpt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Pulse monitor for channel 0 (plus activity summaries)
  int n_press, n_rel, n_long, n_rep, n_ch1, n_multi;
  int press_cyc, rel_cyc, long_cyc;
  int rep_cyc[$];
  int al_diff, n_al_press, al_press_cyc;
  int lvl_bad;

  task automatic clr_mon();
    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; n_ch1 = 0; n_multi = 0;
    press_cyc = -1; rel_cyc = -1; long_cyc = -1;
    rep_cyc.delete();
    n_al_press = 0; al_press_cyc = -1;
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  // cyc is the number of the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (press[0]) begin n_press++; press_cyc = cyc; end
    if (rel[0])   begin n_rel++;   rel_cyc   = cyc; end
    if (lng[0])   begin n_long++;  long_cyc  = cyc; end
    if (rpt[0])   begin n_rep++;   rep_cyc.push_back(cyc); end
    if (press[1] | rel[1] | lng[1] | rpt[1]) n_ch1++;
    if ($countones({press[0], rel[0], lng[0], rpt[0]}) > 1) n_multi++;
    if ({level, press, rel, lng, rpt} !== {al_level, al_press, al_rel, al_lng, al_rpt}) al_diff++;
    if (al_press[0]) begin n_al_press++; al_press_cyc = cyc; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 2'b11;
    repeat (DEB + 4) step();
    n_tests++;
    if ({level, press, rel, lng, rpt} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {level, press, rel, lng, rpt});
    end
    n_tests++;
    if ({al_level, al_press, al_rel, al_lng, al_rpt} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs_al: got %b expected 0", {al_level, al_press, al_rel, al_lng, al_rpt});
    end
    btn = 2'b00;
    rst = 1'b0;
    cyc = 0;
  endtask

  // Button sampled high first at edge 10, held 12 edges (10..21).
  // Press after edge 10+DEB+2=16, release sampled at 22 -> after edge 28.
  task automatic test_clean_press();
    clr_mon();
    lvl_bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (cyc == 9)  btn[0] = 1'b1;
      if (cyc == 21) btn[0] = 1'b0;
      step();
      if (level[0] !== ((cyc >= 16) && (cyc <= 27))) lvl_bad++;
      if (level[1] !== 1'b0) lvl_bad++;
    end
    n_tests++;
    if (n_press !== 1) begin n_fail++; $display("FAIL clean_press_count: got %0d expected 1", n_press); end
    n_tests++;
    if (press_cyc !== 16) begin n_fail++; $display("FAIL clean_press_cycle: got %0d expected 16", press_cyc); end
    n_tests++;
    if (n_rel !== 1) begin n_fail++; $display("FAIL clean_release_count: got %0d expected 1", n_rel); end
    n_tests++;
    if (rel_cyc !== 28) begin n_fail++; $display("FAIL clean_release_cycle: got %0d expected 28", rel_cyc); end
    n_tests++;
    if (n_long !== 0) begin n_fail++; $display("FAIL clean_no_long: got %0d expected 0", n_long); end
    n_tests++;
    if (lvl_bad !== 0) begin n_fail++; $display("FAIL clean_level: got %0d bad cycles expected 0", lvl_bad); end
    n_tests++;
    if (n_ch1 !== 0) begin n_fail++; $display("FAIL clean_ch1_silent: got %0d pulses expected 0", n_ch1); end
  endtask

  // Runs of two equal samples never reach DEB consecutive mismatches.
  task automatic test_bounce();
    clr_mon();
    lvl_bad = 0;
    for (int c = 0; c < 20; c++) begin
      btn[0] = ((c % 4) < 2);
      step();
      if (level[0] !== 1'b0) lvl_bad++;
    end
    btn[0] = 1'b0;
    for (int c = 0; c < 15; c++) begin
      step();
      if (level[0] !== 1'b0) lvl_bad++;
    end
    n_tests++;
    if ((n_press + n_rel + n_long + n_rep) !== 0) begin
      n_fail++;
      $display("FAIL bounce_pulses: got %0d expected 0", n_press + n_rel + n_long + n_rep);
    end
    n_tests++;
    if (lvl_bad !== 0) begin n_fail++; $display("FAIL bounce_level: got %0d bad cycles expected 0", lvl_bad); end
  endtask

  // Press at s, hold edges s+1..s+hold, then release and idle for tail edges.
  task automatic press_hold(input int hold, input int tail, output int s);
    s = cyc;
    btn[0] = 1'b1;
    repeat (hold) step();
    btn[0] = 1'b0;
    repeat (tail) step();
  endtask

  // 60-edge hold: press s+7, long s+27, repeats s+35/43/51/59;
  // release at s+67 coincides with the next repeat and must win.
  task automatic test_long_repeat();
    int s;
    clr_mon();
    rep_en = 1'b1;
    press_hold(60, 25, s);
    n_tests++;
    if (press_cyc !== s + 7) begin n_fail++; $display("FAIL lr_press_cycle: got %0d expected %0d", press_cyc, s + 7); end
    n_tests++;
    if ((n_long !== 1) || (long_cyc !== s + 27)) begin
      n_fail++; $display("FAIL lr_long: got count %0d at %0d expected 1 at %0d", n_long, long_cyc, s + 27);
    end
    n_tests++;
    if (n_rep !== 4) begin n_fail++; $display("FAIL lr_repeat_count: got %0d expected 4", n_rep); end
    n_tests++;
    if ((n_rep < 1) || (rep_cyc[0] !== s + 35)) begin
      n_fail++; $display("FAIL lr_first_repeat: got %0d expected %0d", (n_rep > 0) ? rep_cyc[0] : -1, s + 35);
    end
    n_tests++;
    if ((n_rep < 4) || (rep_cyc[3] !== s + 59)) begin
      n_fail++; $display("FAIL lr_fourth_repeat: got %0d expected %0d", (n_rep > 3) ? rep_cyc[3] : -1, s + 59);
    end
    n_tests++;
    if ((n_rel !== 1) || (rel_cyc !== s + 67)) begin
      n_fail++; $display("FAIL lr_release: got count %0d at %0d expected 1 at %0d", n_rel, rel_cyc, s + 67);
    end
    n_tests++;
    if (n_multi !== 0) begin n_fail++; $display("FAIL lr_one_event_per_cycle: got %0d overlaps expected 0", n_multi); end
  endtask

  task automatic test_long_norepeat();
    int s;
    clr_mon();
    rep_en = 1'b0;
    press_hold(60, 25, s);
    n_tests++;
    if ((n_long !== 1) || (long_cyc !== s + 27)) begin
      n_fail++; $display("FAIL nr_long: got count %0d at %0d expected 1 at %0d", n_long, long_cyc, s + 27);
    end
    n_tests++;
    if (n_rep !== 0) begin n_fail++; $display("FAIL nr_repeat_count: got %0d expected 0", n_rep); end
    n_tests++;
    if ((n_rel !== 1) || (rel_cyc !== s + 67)) begin
      n_fail++; $display("FAIL nr_release: got count %0d at %0d expected 1 at %0d", n_rel, rel_cyc, s + 67);
    end
    rep_en = 1'b1;
  endtask

  task automatic test_enable();
    int s2;
    clr_mon();
    en[0]  = 1'b0;
    btn[0] = 1'b1;
    repeat (40) step();
    n_tests++;
    if (level[0] !== 1'b1) begin n_fail++; $display("FAIL en_level_runs: got %b expected 1", level[0]); end
    en[0] = 1'b1;
    repeat (30) step();
    n_tests++;
    if ((n_press + n_rel + n_long + n_rep) !== 0) begin
      n_fail++; $display("FAIL en_suppressed: got %0d pulses expected 0", n_press + n_rel + n_long + n_rep);
    end
    btn[0] = 1'b0;
    repeat (12) step();
    n_tests++;
    if ((n_rel !== 0) || (level[0] !== 1'b0)) begin
      n_fail++; $display("FAIL en_release_silent: got rel %0d level %b expected 0 0", n_rel, level[0]);
    end
    s2 = cyc;
    btn[0] = 1'b1;
    repeat (10) step();
    n_tests++;
    if ((n_press !== 1) || (press_cyc !== s2 + 7)) begin
      n_fail++; $display("FAIL en_repress: got count %0d at %0d expected 1 at %0d", n_press, press_cyc, s2 + 7);
    end
    btn[0] = 1'b0;
    repeat (12) step();
  endtask

  // Reset taken at edge R while in LONG; first edge sampling the held button
  // afterwards is R+1, so the new press appears after edge R+1+DEB+2.
  task automatic test_reset_mid_long();
    int r;
    clr_mon();
    btn[0] = 1'b1;
    repeat (30) step();
    n_tests++;
    if (n_long !== 1) begin n_fail++; $display("FAIL rml_reached_long: got %0d expected 1", n_long); end
    rst = 1'b1;
    step();
    r = cyc;
    n_tests++;
    if ({level, press, rel, lng, rpt} !== 10'b0) begin
      n_fail++; $display("FAIL rml_outputs_cleared: got %b expected 0", {level, press, rel, lng, rpt});
    end
    rst = 1'b0;
    clr_mon();
    repeat (10) step();
    n_tests++;
    if ((n_press !== 1) || (press_cyc !== r + 7)) begin
      n_fail++; $display("FAIL rml_press_after_reset: got count %0d at %0d expected 1 at %0d", n_press, press_cyc, r + 7);
    end
    n_tests++;
    if (n_rel !== 0) begin n_fail++; $display("FAIL rml_no_release: got %0d expected 0", n_rel); end
    btn[0] = 1'b0;
    repeat (12) step();
  endtask

  task automatic test_active_low();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    cyc = 0;
    clr_mon();
    al_diff = 0;
    for (int c = 0; c < 40; c++) begin
      if (cyc == 9)  btn[0] = 1'b1;
      if (cyc == 21) btn[0] = 1'b0;
      step();
    end
    n_tests++;
    if ((n_al_press !== 1) || (al_press_cyc !== 16)) begin
      n_fail++; $display("FAIL al_press: got count %0d at %0d expected 1 at 16", n_al_press, al_press_cyc);
    end
    n_tests++;
    if (al_diff !== 0) begin n_fail++; $display("FAIL al_identical: got %0d differing cycles expected 0", al_diff); end
  endtask

  initial begin
    al_diff = 0;
    clr_mon();
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_repeat();
    test_long_norepeat();
    test_enable();
    test_reset_mid_long();
    test_active_low();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
